// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: decoded-field stream feeding the instruction encoder.
// The master drives the fields and valid; the slave returns ready.
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [2:0]  in_funct3;
  logic        in_f7b5;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [20:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_kind, in_funct3, in_f7b5,
    output in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_f7b5,
    input  in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes decoded fields into RV32I words and loads imem.
// Define IMM_RANGE_CHECK_EN to reject out-of-range or misaligned immediates.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_encoder_loader_if.slave fld,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W:0]       count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] AMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_FIN
  } state_t;

  state_t      state, nstate;
  logic [31:0] enc;
  logic        bad;
  logic        last_q;
  logic        at_end;

  logic [20:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;

  assign imm    = fld.in_imm;
  assign rd     = fld.in_rd;
  assign rs1    = fld.in_rs1;
  assign rs2    = fld.in_rs2;
  assign f3     = fld.in_funct3;
  assign at_end = last_q || (mem_addr == AMAX);

`ifdef IMM_RANGE_CHECK_EN
  logic ok12, ok13;
  assign ok12 = (&imm[20:11]) || !(|imm[20:11]);
  assign ok13 = (&imm[20:12]) || !(|imm[20:12]);
`endif

  always_comb begin
    enc = '0;
    bad = 1'b0;
    unique case (fld.in_kind)
      3'd0: enc = {imm[11:0], rs1, f3, rd, 7'b0000011};
      3'd1: enc = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      3'd2: enc = {1'b0, fld.in_f7b5, 5'b00000, rs2, rs1, f3, rd,
                   7'b0110011};
      3'd3: enc = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1],
                   imm[11], 7'b1100011};
      3'd4: enc = {imm[11:0], rs1, f3, rd, 7'b0010011};
      3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd,
                   7'b1101111};
      default: bad = 1'b1;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    unique case (fld.in_kind)
      3'd0, 3'd1, 3'd4: if (!ok12) bad = 1'b1;
      3'd3: if (!ok13 || imm[0]) bad = 1'b1;
      3'd5: if (imm[0]) bad = 1'b1;
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:   if (start) nstate = S_ACCEPT;
      S_ACCEPT: if (fld.in_valid) begin
        if (!bad)             nstate = S_WRITE;
        else if (fld.in_last) nstate = S_FIN;
      end
      S_WRITE:  nstate = at_end ? S_FIN : S_ACCEPT;
      S_FIN:    nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  always_comb begin
    fld.in_ready = (state == S_ACCEPT);
    mem_we       = (state == S_WRITE);
    busy         = (state != S_IDLE);
    done         = (state == S_FIN);
  end

  // Datapath registers; address holds at the top word instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= BASE;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          err      <= 1'b0;
          count    <= '0;
          mem_addr <= BASE;
        end
        S_ACCEPT: if (fld.in_valid) begin
          if (bad) begin
            err <= 1'b1;
          end else begin
            mem_wdata <= enc;
            last_q    <= fld.in_last;
          end
        end
        S_WRITE: begin
          count <= count + 1'b1;
          if (!last_q) begin
            if (mem_addr == AMAX) err <= 1'b1;
            else                  mem_addr <= mem_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed vectors for the encoder/loader.
// A second ADDR_W=2 instance exercises the address-overflow stop.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_b = 1'b0;
  logic start_s = 1'b0;
  logic v = 1'b0;
  logic sel = 1'b0;
  logic [2:0] kind = '0;
  logic [2:0] f3 = '0;
  logic f7 = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [20:0] imm = '0;
  logic last = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder_loader_if b();
  instr_encoder_loader_if s();

  assign b.in_valid  = v & ~sel;
  assign b.in_kind   = kind;
  assign b.in_funct3 = f3;
  assign b.in_f7b5   = f7;
  assign b.in_rd     = rd;
  assign b.in_rs1    = rs1;
  assign b.in_rs2    = rs2;
  assign b.in_imm    = imm;
  assign b.in_last   = last;

  assign s.in_valid  = v & sel;
  assign s.in_kind   = kind;
  assign s.in_funct3 = f3;
  assign s.in_f7b5   = f7;
  assign s.in_rd     = rd;
  assign s.in_rs1    = rs1;
  assign s.in_rs2    = rs2;
  assign s.in_imm    = imm;
  assign s.in_last   = last;

  logic        we_b, busy_b, done_b, err_b;
  logic [7:0]  addr_b;
  logic [31:0] wd_b;
  logic [8:0]  cnt_b;
  logic        we_s, busy_s, done_s, err_s;
  logic [1:0]  addr_s;
  logic [31:0] wd_s;
  logic [2:0]  cnt_s;

  instr_encoder_loader u_big (
    .clk(clk), .rst(rst), .start(start_b), .fld(b.slave),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
    .busy(busy_b), .done(done_b), .err(err_b), .count(cnt_b)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .fld(s.slave),
    .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(wd_s),
    .busy(busy_s), .done(done_s), .err(err_s), .count(cnt_s)
  );

  logic        rdy, we, busy, done, err;
  logic [7:0]  addr;
  logic [31:0] wd;
  logic [8:0]  cnt;

  assign rdy  = sel ? s.in_ready : b.in_ready;
  assign we   = sel ? we_s : we_b;
  assign busy = sel ? busy_s : busy_b;
  assign done = sel ? done_s : done_b;
  assign err  = sel ? err_s : err_b;
  assign addr = sel ? {6'b0, addr_s} : addr_b;
  assign wd   = sel ? wd_s : wd_b;
  assign cnt  = sel ? {6'b0, cnt_s} : cnt_b;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] k, input logic [2:0] f,
                      input logic f7b5, input logic [4:0] d,
                      input logic [4:0] a, input logic [4:0] c,
                      input logic [20:0] im, input logic l);
    int n;
    kind = k; f3 = f; f7 = f7b5; rd = d; rs1 = a; rs2 = c;
    imm = im; last = l; v = 1'b1; n = 0;
    while (!rdy && n < 20) begin
      tick();
      n++;
    end
    chk("accept", {31'b0, n < 20}, 32'd1);
    tick();
    v = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [7:0] a,
                    input logic [31:0] d);
    chk({tag, "_we"}, {31'b0, we}, 32'd1);
    chk({tag, "_addr"}, {24'b0, addr}, {24'b0, a});
    chk({tag, "_data"}, wd, d);
    tick();
    chk({tag, "_we_off"}, {31'b0, we}, 32'd0);
  endtask

  task automatic fin(input string tag, input logic [8:0] c,
                     input logic e);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    chk({tag, "_count"}, {23'b0, cnt}, {23'b0, c});
    chk({tag, "_err"}, {31'b0, err}, {31'b0, e});
    tick();
    chk({tag, "_done_off"}, {31'b0, done}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic go_b();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ready", {31'b0, rdy}, 32'd0);
    chk("rst_we", {31'b0, we}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_addr", {24'b0, addr}, 32'd0);
    chk("rst_wdata", wd, 32'd0);
    chk("rst_count", {23'b0, cnt}, 32'd0);
    rst = 1'b1;
    tick();

    go_b();
    chk("t1_busy", {31'b0, busy}, 32'd1);
    chk("t1_ready", {31'b0, rdy}, 32'd1);
    send(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b1);
    wr("t1_addi", 8'd0, 32'h00500093);
    fin("t1", 9'd1, 1'b0);

    go_b();
    send(3'd0, 3'd2, 1'b0, 5'd2, 5'd1, 5'd0, 21'd8, 1'b0);
    wr("t2_lw", 8'd0, 32'h0080A103);
    send(3'd1, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 21'd12, 1'b1);
    wr("t2_sw", 8'd1, 32'h0020A623);
    fin("t2", 9'd2, 1'b0);

    go_b();
    send(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
    wr("t3_add", 8'd0, 32'h002081B3);
    send(3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
    wr("t3_sub", 8'd1, 32'h402081B3);
    send(3'd3, 3'd5, 1'b0, 5'd0, 5'd1, 5'd2, 21'd8, 1'b0);
    wr("t3_beq", 8'd2, 32'h00208463);
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, -21'sd4, 1'b1);
    wr("t3_jal", 8'd3, 32'hFFDFF0EF);
    fin("t3", 9'd4, 1'b0);

    go_b();
    send(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b0);
    wr("t4_addi", 8'd0, 32'h00500093);
    send(3'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b0);
    chk("t4_bad_we", {31'b0, we}, 32'd0);
    chk("t4_bad_err", {31'b0, err}, 32'd1);
    chk("t4_bad_ready", {31'b0, rdy}, 32'd1);
    send(3'd0, 3'd2, 1'b0, 5'd2, 5'd1, 5'd0, 21'd8, 1'b1);
    wr("t4_lw", 8'd1, 32'h0080A103);
    fin("t4", 9'd2, 1'b1);
    chk("t4_err_sticky", {31'b0, err}, 32'd1);
    go_b();
    chk("t4_err_clr", {31'b0, err}, 32'd0);
    chk("t4_cnt_clr", {23'b0, cnt}, 32'd0);
    send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b1);
    fin("t4_last_bad", 9'd0, 1'b1);

    go_b();
    send(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd2048, 1'b1);
`ifdef IMM_RANGE_CHECK_EN
    chk("t5_we", {31'b0, we}, 32'd0);
    fin("t5", 9'd0, 1'b1);
`else
    wr("t5_addi", 8'd0, 32'h80000093);
    fin("t5", 9'd1, 1'b0);
`endif

    go_b();
    send(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b0);
    chk("t6_we", {31'b0, we}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_we_rst", {31'b0, we}, 32'd0);
    chk("t6_busy_rst", {31'b0, busy}, 32'd0);
    chk("t6_wd_rst", wd, 32'd0);
    chk("t6_cnt_rst", {23'b0, cnt}, 32'd0);
    chk("t6_done_rst", {31'b0, done}, 32'd0);
    v = 1'b1;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_accept", {31'b0, rdy}, 32'd0);
      chk("t6_no_we", {31'b0, we}, 32'd0);
    end
    v = 1'b0;

    sel = 1'b1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(3'd4, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 21'(i), 1'b0);
      wr("t7_ovf", 8'(i), {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13});
    end
    fin("t7", 9'd4, 1'b1);
    kind = 3'd4;
    v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t7_no_accept", {31'b0, rdy}, 32'd0);
      chk("t7_no_we", {31'b0, we}, 32'd0);
      tick();
    end
    v = 1'b0;
    chk("t7_addr_hold", {24'b0, addr}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
